vrc_mem_arbiter: RTL and testbench

- Time-shares one external cartridge memory port between three requesters: CPU PRG fetch (bus.prg_addr path), PPU CHR fetch (bus.chr_addr path), and periodic memory refresh.
- Sits between the VRC mapper address outputs and the memory controller.
- Fixed priority with a starvation guard on PRG and deadline escalation on refresh.
- One transaction outstanding at a time.

---
 rtl/vrc_mem_pkg.sv | 33 +++
 rtl/vrc_mem_arbiter_if.sv | 52 +++++
 rtl/vrc_mem_prio.sv | 33 +++
 rtl/vrc_mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_vrc_mem_arbiter.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/vrc_mem_pkg.sv
// Shared types for the VRC cartridge memory arbiter: FSM states, request owners
// and the latched memory command.
package vrc_mem_pkg;

  localparam int CMD_ADDR_BITS = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Owner values double as bit positions in the one-hot grant vector.
  typedef enum logic [1:0] {
    OWN_CHR = 2'd0,
    OWN_PRG = 2'd1,
    OWN_REF = 2'd2
  } owner_t;

  typedef struct packed {
    logic [CMD_ADDR_BITS-1:0] addr;
    logic                     we;
    logic [7:0]               wdata;
    logic                     refresh;
  } mem_cmd_t;

  function automatic owner_t grant_owner(input logic [2:0] grant);
    if (grant[OWN_PRG])      return OWN_PRG;
    else if (grant[OWN_REF]) return OWN_REF;
    else                     return OWN_CHR;
  endfunction

endpackage

// File: rtl/vrc_mem_arbiter_if.sv
// Requester and memory-controller signals of the VRC memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface vrc_mem_arbiter_if
  import vrc_mem_pkg::*;
#(
  parameter int ADDR_BITS = CMD_ADDR_BITS
);
  logic                 chr_req;
  logic [ADDR_BITS-1:0] chr_addr;
  logic                 chr_we;
  logic [7:0]           chr_wdata;
  logic                 chr_ack;
  logic [7:0]           chr_rdata;

  logic                 prg_req;
  logic [ADDR_BITS-1:0] prg_addr;
  logic                 prg_we;
  logic [7:0]           prg_wdata;
  logic                 prg_ack;
  logic [7:0]           prg_rdata;

  logic                 ref_tick;

  logic                 mem_valid;
  logic                 mem_ready;
  logic                 mem_refresh;
  logic [ADDR_BITS-1:0] mem_addr;
  logic                 mem_we;
  logic [7:0]           mem_wdata;
  logic                 mem_done;
  logic [7:0]           mem_rdata;

  modport slave (
    input  chr_req, chr_addr, chr_we, chr_wdata,
    output chr_ack, chr_rdata,
    input  prg_req, prg_addr, prg_we, prg_wdata,
    output prg_ack, prg_rdata,
    input  ref_tick,
    output mem_valid, mem_refresh, mem_addr, mem_we, mem_wdata,
    input  mem_ready, mem_done, mem_rdata
  );

  modport master (
    output chr_req, chr_addr, chr_we, chr_wdata,
    input  chr_ack, chr_rdata,
    output prg_req, prg_addr, prg_we, prg_wdata,
    input  prg_ack, prg_rdata,
    output ref_tick,
    input  mem_valid, mem_refresh, mem_addr, mem_we, mem_wdata,
    output mem_ready, mem_done, mem_rdata
  );
endinterface

// File: rtl/vrc_mem_prio.sv
// Combinational priority selector: urgent refresh, starved PRG, CHR,
// pending refresh, PRG. Produces a one-hot grant indexed by owner_t.
module vrc_mem_prio
  import vrc_mem_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int REF_MAX  = 4,
  parameter int WAIT_W   = 4,
  parameter int REF_W    = 3
) (
  input  logic              i_chr_req,
  input  logic              i_prg_req,
  input  logic [REF_W-1:0]  i_ref_pend,
  input  logic [WAIT_W-1:0] i_wait_cnt,
  output logic [2:0]        o_grant
);

  // NOTE: o_grant is cleared before the if-chain so every path assigns it and no latch is inferred.
  always_comb begin
    o_grant = '0;
    if (i_ref_pend == REF_W'(REF_MAX))
      o_grant[OWN_REF] = 1'b1;
    else if (i_prg_req && i_wait_cnt == WAIT_W'(MAX_WAIT))
      o_grant[OWN_PRG] = 1'b1;
    else if (i_chr_req)
      o_grant[OWN_CHR] = 1'b1;
    else if (i_ref_pend != '0)
      o_grant[OWN_REF] = 1'b1;
    else if (i_prg_req)
      o_grant[OWN_PRG] = 1'b1;
  end

endmodule

// File: rtl/vrc_mem_arbiter.sv
// Time-shares one cartridge memory port between PPU CHR fetch, CPU PRG fetch and
// refresh, one transaction at a time, with PRG starvation guard and refresh escalation.
module vrc_mem_arbiter
  import vrc_mem_pkg::*;
#(
  parameter int ADDR_BITS = CMD_ADDR_BITS,
  parameter int MAX_WAIT  = 15,
  parameter int REF_MAX   = 4
) (
  input logic               clk,
  input logic               reset_n,
  vrc_mem_arbiter_if.slave  bus
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int REF_W  = $clog2(REF_MAX + 1);

  state_t            r_state;
  state_t            w_state_nxt;
  owner_t            r_owner;
  owner_t            w_winner;
  mem_cmd_t          r_cmd;
  mem_cmd_t          w_cmd_sel;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [REF_W-1:0]  r_ref_pend;
  logic              r_chr_ack;
  logic              r_prg_ack;
  logic [7:0]        r_chr_rdata;
  logic [7:0]        r_prg_rdata;
  logic [2:0]        w_grant;
  logic              w_mem_valid;
  logic              w_decide;
  logic              w_accept;
  logic              w_done;
  logic              w_ref_acc;

  vrc_mem_prio #(
    .MAX_WAIT (MAX_WAIT),
    .REF_MAX  (REF_MAX),
    .WAIT_W   (WAIT_W),
    .REF_W    (REF_W)
  ) u_prio (
    .i_chr_req  (bus.chr_req),
    .i_prg_req  (bus.prg_req),
    .i_ref_pend (r_ref_pend),
    .i_wait_cnt (r_wait_cnt),
    .o_grant    (w_grant)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mem_valid = 1'b0;
    case (r_state)
      IDLE:    if (|w_grant) w_state_nxt = ISSUE;
      ISSUE: begin
        w_mem_valid = 1'b1;
        if (bus.mem_ready) w_state_nxt = WAIT;
      end
      WAIT:    if (bus.mem_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_decide  = (r_state == IDLE) && (|w_grant);
  assign w_accept  = w_mem_valid && bus.mem_ready;
  assign w_done    = (r_state == WAIT) && bus.mem_done;
  assign w_ref_acc = w_accept && r_cmd.refresh;

  // Refresh commands carry no address or data; those fields are left at zero.
  always_comb begin
    w_cmd_sel = '0;
    w_winner  = grant_owner(w_grant);
    case (w_winner)
      OWN_CHR: begin
        w_cmd_sel.addr  = CMD_ADDR_BITS'(bus.chr_addr);
        w_cmd_sel.we    = bus.chr_we;
        w_cmd_sel.wdata = bus.chr_wdata;
      end
      OWN_PRG: begin
        w_cmd_sel.addr  = CMD_ADDR_BITS'(bus.prg_addr);
        w_cmd_sel.we    = bus.prg_we;
        w_cmd_sel.wdata = bus.prg_wdata;
      end
      OWN_REF: w_cmd_sel.refresh = 1'b1;
      default: w_cmd_sel = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner     <= OWN_CHR;
      r_cmd       <= '0;
      r_wait_cnt  <= '0;
      r_ref_pend  <= '0;
      r_chr_ack   <= 1'b0;
      r_prg_ack   <= 1'b0;
      r_chr_rdata <= '0;
      r_prg_rdata <= '0;
    end else begin
      r_chr_ack <= 1'b0;
      r_prg_ack <= 1'b0;

      if (w_decide) begin
        r_owner <= w_winner;
        r_cmd   <= w_cmd_sel;
      end

      if (r_state == IDLE) begin
        if (bus.prg_req && !w_grant[OWN_PRG]) begin
          if (r_wait_cnt != WAIT_W'(MAX_WAIT)) r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
        end else begin
          r_wait_cnt <= '0;
        end
      end

      // A tick landing on the same edge as a refresh accept cancels out.
      if (bus.ref_tick && !w_ref_acc) begin
        if (r_ref_pend != REF_W'(REF_MAX)) r_ref_pend <= r_ref_pend + REF_W'(1);
      end else if (!bus.ref_tick && w_ref_acc) begin
        r_ref_pend <= r_ref_pend - REF_W'(1);
      end

      if (w_done) begin
        if (r_owner == OWN_CHR) begin
          r_chr_ack   <= 1'b1;
          r_chr_rdata <= bus.mem_rdata;
        end else if (r_owner == OWN_PRG) begin
          r_prg_ack   <= 1'b1;
          r_prg_rdata <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.mem_valid   = w_mem_valid;
  assign bus.mem_refresh = r_cmd.refresh;
  assign bus.mem_addr    = ADDR_BITS'(r_cmd.addr);
  assign bus.mem_we      = r_cmd.we;
  assign bus.mem_wdata   = r_cmd.wdata;
  assign bus.chr_ack     = r_chr_ack;
  assign bus.chr_rdata   = r_chr_rdata;
  assign bus.prg_ack     = r_prg_ack;
  assign bus.prg_rdata   = r_prg_rdata;

endmodule

// File: tb/tb_vrc_mem_arbiter.sv
// Directed bench for vrc_mem_arbiter: single reads/writes, PRG starvation guard,
// refresh escalation and cancellation, and reset during an outstanding transaction.
module tb_vrc_mem_arbiter;
  import vrc_mem_pkg::*;

  typedef struct {
    logic [23:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic        refr;
    logic        chr_ack;
    logic        prg_ack;
    logic [7:0]  chr_rd;
    logic [7:0]  prg_rd;
    logic        stable;
  } txn_t;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  vrc_mem_arbiter_if #(.ADDR_BITS(24)) bus ();

  vrc_mem_arbiter #(
    .ADDR_BITS (24),
    .MAX_WAIT  (15),
    .REF_MAX   (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for a command, holds mem_ready low for ready_lat cycles, completes it
  // done_lat cycles after accept, and records what the arbiter presented and returned.
  task automatic serve(input int ready_lat, input int done_lat, input logic [7:0] rd,
                       input logic pulse, output txn_t t);
    int n = 0;
    t = '{addr: '0, we: 1'b0, wdata: '0, refr: 1'b0, chr_ack: 1'b0, prg_ack: 1'b0,
          chr_rd: '0, prg_rd: '0, stable: 1'b0};
    while (!bus.mem_valid && n < 20) begin
      tick();
      n++;
    end
    if (!bus.mem_valid) begin
      check("valid_timeout", 32'(bus.mem_valid), 32'd1);
      return;
    end
    t.addr   = bus.mem_addr;
    t.we     = bus.mem_we;
    t.wdata  = bus.mem_wdata;
    t.refr   = bus.mem_refresh;
    t.stable = 1'b1;
    bus.ref_tick = pulse;
    for (int i = 0; i < ready_lat; i++) begin
      tick();
      bus.ref_tick = 1'b0;
      if (!bus.mem_valid || bus.mem_addr !== t.addr || bus.mem_we !== t.we ||
          bus.mem_wdata !== t.wdata) t.stable = 1'b0;
    end
    bus.mem_ready = 1'b1;
    tick();
    bus.ref_tick  = 1'b0;
    bus.mem_ready = 1'b0;
    for (int i = 1; i < done_lat; i++) tick();
    bus.mem_done  = 1'b1;
    bus.mem_rdata = rd;
    tick();
    bus.mem_done  = 1'b0;
    t.chr_ack = bus.chr_ack;
    t.prg_ack = bus.prg_ack;
    t.chr_rd  = bus.chr_rdata;
    t.prg_rd  = bus.prg_rdata;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    txn_t t;
    txn_t last;
    int   first_prg;
    int   n_chr;
    int   n;

    bus.chr_req = 0; bus.chr_addr = '0; bus.chr_we = 0; bus.chr_wdata = '0;
    bus.prg_req = 0; bus.prg_addr = '0; bus.prg_we = 0; bus.prg_wdata = '0;
    bus.ref_tick = 0; bus.mem_ready = 0; bus.mem_done = 0; bus.mem_rdata = '0;
    reset_n = 1'b0;

    #12;
    check("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_refresh", 32'(bus.mem_refresh), 32'd0);
    check("rst_chr_ack", 32'(bus.chr_ack), 32'd0);
    check("rst_prg_ack", 32'(bus.prg_ack), 32'd0);
    check("rst_ref_pend", 32'(dut.r_ref_pend), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Single CHR read, done two cycles after accept.
    bus.chr_req = 1; bus.chr_addr = 24'h001234; bus.chr_we = 0;
    serve(0, 2, 8'hA5, 1'b0, t);
    bus.chr_req = 0;
    check("chr_rd_addr", 32'(t.addr), 32'h001234);
    check("chr_rd_we", 32'(t.we), 32'd0);
    check("chr_rd_ack", 32'(t.chr_ack), 32'd1);
    check("chr_rd_data", 32'(t.chr_rd), 32'hA5);
    check("chr_rd_no_prg_ack", 32'(t.prg_ack), 32'd0);
    tick();
    check("chr_ack_one_cycle", 32'(bus.chr_ack), 32'd0);
    check("chr_rdata_hold", 32'(bus.chr_rdata), 32'hA5);

    // PRG write stalled by mem_ready low for 5 cycles.
    bus.prg_req = 1; bus.prg_addr = 24'h008000; bus.prg_we = 1; bus.prg_wdata = 8'h3C;
    serve(5, 1, 8'h77, 1'b0, t);
    bus.prg_req = 0;
    check("prg_wr_addr", 32'(t.addr), 32'h008000);
    check("prg_wr_we", 32'(t.we), 32'd1);
    check("prg_wr_wdata", 32'(t.wdata), 32'h3C);
    check("prg_wr_stable", 32'(t.stable), 32'd1);
    check("prg_wr_ack", 32'(t.prg_ack), 32'd1);
    check("prg_wr_no_chr_ack", 32'(t.chr_ack), 32'd0);
    tick();
    check("prg_ack_single", 32'(bus.prg_ack), 32'd0);
    check("prg_idle_after", 32'(bus.mem_valid), 32'd0);

    // Both held: 15 CHR grants, then the starved PRG.
    bus.prg_we = 0;
    bus.chr_req = 1; bus.chr_addr = 24'h000100;
    bus.prg_req = 1; bus.prg_addr = 24'h008000;
    first_prg = -1;
    n_chr = 0;
    for (int k = 0; k < 16; k++) begin
      serve(0, 1, 8'(k), 1'b0, t);
      if (t.chr_ack) n_chr++;
      if (t.prg_ack && first_prg < 0) first_prg = k;
      last = t;
    end
    bus.chr_req = 0;
    bus.prg_req = 0;
    check("starve_chr_grants", 32'(n_chr), 32'd15);
    check("starve_first_prg", 32'(first_prg), 32'd15);
    check("starve_16th_addr", 32'(last.addr), 32'h008000);
    check("starve_16th_rdata", 32'(last.prg_rd), 32'd15);
    check("starve_wait_clear", 32'(dut.r_wait_cnt), 32'd0);

    // Four ticks during CHR traffic escalate refresh ahead of CHR.
    bus.chr_req = 1; bus.chr_addr = 24'h000200;
    n_chr = 0;
    for (int k = 0; k < 4; k++) begin
      serve(0, 1, 8'h40 + 8'(k), 1'b1, t);
      if (t.chr_ack && !t.refr) n_chr++;
    end
    check("ref_chr_first4", 32'(n_chr), 32'd4);
    check("ref_pend_sat", 32'(dut.r_ref_pend), 32'd4);
    serve(0, 1, 8'h00, 1'b0, t);
    check("ref_fifth_refresh", 32'(t.refr), 32'd1);
    check("ref_no_acks", 32'({t.chr_ack, t.prg_ack}), 32'd0);
    check("ref_pend_dec", 32'(dut.r_ref_pend), 32'd3);
    check("ref_chr_rdata_hold", 32'(t.chr_rd), 32'h43);
    bus.chr_req = 0;

    // Drain to 2, then a tick coincident with a refresh accept.
    serve(0, 1, 8'h00, 1'b0, t);
    check("drain_refresh", 32'(t.refr), 32'd1);
    check("drain_pend2", 32'(dut.r_ref_pend), 32'd2);
    serve(0, 1, 8'h00, 1'b1, t);
    check("coincide_refresh", 32'(t.refr), 32'd1);
    check("coincide_pend", 32'(dut.r_ref_pend), 32'd2);
    serve(0, 1, 8'h00, 1'b0, t);
    serve(0, 1, 8'h00, 1'b0, t);
    check("drain_pend0", 32'(dut.r_ref_pend), 32'd0);
    tick();
    check("drain_idle", 32'(bus.mem_valid), 32'd0);

    // Reset while waiting for mem_done, then a stray mem_done.
    bus.chr_req = 1; bus.chr_addr = 24'h00ABCD;
    n = 0;
    while (!bus.mem_valid && n < 20) begin
      tick();
      n++;
    end
    check("rstw_valid", 32'(bus.mem_valid), 32'd1);
    bus.mem_ready = 1;
    tick();
    bus.mem_ready = 0;
    bus.chr_req = 0;
    check("rstw_in_wait", 32'(dut.r_state), 32'(WAIT));
    check("rstw_addr_pre", 32'(bus.mem_addr), 32'h00ABCD);
    #2;
    reset_n = 1'b0;
    #1;
    check("rstw_async_addr", 32'(bus.mem_addr), 32'd0);
    check("rstw_async_valid", 32'(bus.mem_valid), 32'd0);
    check("rstw_async_chr_rdata", 32'(bus.chr_rdata), 32'd0);
    check("rstw_async_prg_rdata", 32'(bus.prg_rdata), 32'd0);
    check("rstw_async_state", 32'(dut.r_state), 32'(IDLE));
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    bus.mem_done = 1; bus.mem_rdata = 8'hEE;
    tick();
    bus.mem_done = 0;
    check("stray_done_no_ack", 32'(bus.chr_ack), 32'd0);
    check("stray_done_rdata", 32'(bus.chr_rdata), 32'd0);
    check("stray_done_idle", 32'(dut.r_state), 32'(IDLE));
    tick();
    check("stray_done_no_valid", 32'(bus.mem_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
